// File: rtl/bram_sd_sync_if.sv
// SD sector bus (hps_io side) and backup-RAM port-B bus of the persistence controller.
// master = the controller, slave = hps_io plus the RAM port it feeds.
interface bram_sd_sync_if #(
    parameter int SECTORS = 16
);
    localparam int SEC_W = $clog2(SECTORS);

    logic [31:0]      sd_lba;
    logic             sd_rd;
    logic             sd_wr;
    logic             sd_ack;
    logic [7:0]       sd_buff_addr;
    logic [15:0]      sd_buff_dout;
    logic             sd_buff_wr;
    logic [SEC_W+7:0] bram_b_addr;
    logic [15:0]      bram_b_din;
    logic             bram_b_we;

    modport master (
        output sd_lba, sd_rd, sd_wr, bram_b_addr, bram_b_din, bram_b_we,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
    );

    modport slave (
        input  sd_lba, sd_rd, sd_wr, bram_b_addr, bram_b_din, bram_b_we,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
    );
endinterface

// File: rtl/bram_sd_sync.sv
// Backup-RAM persistence controller: multi-sector load/save of a save slot over
// the hps_io SD interface, HuBM header format, and idle-time autosave.
module bram_sd_sync #(
    parameter int          SECTORS         = 16,
    parameter int          SLOTS           = 4,
    parameter logic [23:0] AUTOSAVE_CYCLES = 24'd10_000_000,
    localparam int         SEC_W           = $clog2(SECTORS),
    localparam int         SLOT_W          = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              bk_ena,
    input  logic              load_req,
    input  logic              save_req,
    input  logic              format_req,
    input  logic              autosave_en,
    input  logic [SLOT_W-1:0] slot,
    input  logic              core_bram_we,
    bram_sd_sync_if.master    bus,
    output logic              busy,
    output logic              loading,
    output logic              dirty
);
    localparam int ADDR_W = SEC_W + 8;

    typedef enum logic [2:0] {IDLE, REQ, WAIT_ACK, WAIT_DONE, FORMAT} state_t;

    state_t            state, state_d;
    logic [SEC_W-1:0]  sec_cnt, sec_cnt_d, sec_inc;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [1:0]        fmt_cnt, fmt_cnt_d;
    logic [31:0]       lba_q, lba_d;
    logic              rd_q, rd_d, wr_q, wr_d;
    logic              busy_q, busy_d, loading_q, loading_d, dirty_q, dirty_d;
    logic [23:0]       timer_q, timer_d;
    logic              load_prev, save_prev, fmt_prev, ack_prev;
    logic              load_go, save_go, fmt_go, auto_go, auto_taken;
    logic              ack_rise, ack_fall;

    function automatic logic [31:0] make_lba(input logic [SLOT_W-1:0] s, input logic [SEC_W-1:0] c);
        make_lba = 32'({s, c});
    endfunction

    function automatic logic [15:0] hdr_word(input logic [1:0] i);
        case (i)
            2'd0:    hdr_word = 16'h5548;
            2'd1:    hdr_word = 16'h4D42;
            2'd2:    hdr_word = 16'h8800;
            default: hdr_word = 16'h8010;
        endcase
    endfunction

    assign load_go  = load_req & ~load_prev & bk_ena;
    assign save_go  = save_req & ~save_prev & bk_ena;
    assign fmt_go   = format_req & ~fmt_prev;
    assign auto_go  = (timer_q == AUTOSAVE_CYCLES) & dirty_q & autosave_en & bk_ena;
    assign ack_rise = bus.sd_ack & ~ack_prev;
    assign ack_fall = ~bus.sd_ack & ack_prev;
    assign sec_inc  = sec_cnt + SEC_W'(1);

    always_comb begin
        state_d    = state;
        sec_cnt_d  = sec_cnt;
        slot_d     = slot_q;
        fmt_cnt_d  = fmt_cnt;
        lba_d      = lba_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        busy_d     = busy_q;
        loading_d  = loading_q;
        dirty_d    = dirty_q;
        timer_d    = timer_q;
        auto_taken = 1'b0;

        case (state)
            IDLE: begin
                if (load_go || save_go || (auto_go && !fmt_go)) begin
                    auto_taken = !load_go && !save_go;
                    state_d    = REQ;
                    slot_d     = slot;
                    sec_cnt_d  = '0;
                    lba_d      = make_lba(slot, '0);
                    busy_d     = 1'b1;
                    loading_d  = load_go;
                    if (!load_go) dirty_d = 1'b0;
                    if (auto_taken) timer_d = '0;
                end else if (fmt_go) begin
                    state_d   = FORMAT;
                    fmt_cnt_d = 2'd0;
                    busy_d    = 1'b1;
                end
            end
            REQ: begin
                rd_d    = loading_q;
                wr_d    = ~loading_q;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ack_rise) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (ack_fall) begin
                    if (sec_cnt == SEC_W'(SECTORS - 1)) begin
                        state_d   = IDLE;
                        busy_d    = 1'b0;
                        loading_d = 1'b0;
                        if (loading_q) dirty_d = 1'b0;
                    end else begin
                        sec_cnt_d = sec_inc;
                        lba_d     = make_lba(slot_q, sec_inc);
                        state_d   = REQ;
                    end
                end
            end
            FORMAT: begin
                fmt_cnt_d = fmt_cnt + 2'd1;
                if (fmt_cnt == 2'd3) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A core write outranks any clear from a save start or load completion.
        if (core_bram_we) begin
            dirty_d = 1'b1;
            timer_d = '0;
        end else if (!auto_taken && dirty_q && state == IDLE && timer_q != AUTOSAVE_CYCLES) begin
            timer_d = timer_q + 24'd1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state     <= IDLE;
            sec_cnt   <= '0;
            slot_q    <= '0;
            fmt_cnt   <= '0;
            lba_q     <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            busy_q    <= 1'b0;
            loading_q <= 1'b0;
            dirty_q   <= 1'b0;
            timer_q   <= '0;
        end else begin
            state     <= state_d;
            sec_cnt   <= sec_cnt_d;
            slot_q    <= slot_d;
            fmt_cnt   <= fmt_cnt_d;
            lba_q     <= lba_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            busy_q    <= busy_d;
            loading_q <= loading_d;
            dirty_q   <= dirty_d;
            timer_q   <= timer_d;
        end
        // Edge detectors track the levels through reset so a held level is not an edge.
        load_prev <= load_req;
        save_prev <= save_req;
        fmt_prev  <= format_req;
        ack_prev  <= bus.sd_ack;
    end

    always_comb begin
        bus.bram_b_addr = '0;
        bus.bram_b_din  = '0;
        bus.bram_b_we   = 1'b0;
        case (state)
            FORMAT: begin
                bus.bram_b_addr = {{(ADDR_W-2){1'b0}}, fmt_cnt};
                bus.bram_b_din  = hdr_word(fmt_cnt);
                bus.bram_b_we   = 1'b1;
            end
            REQ, WAIT_ACK, WAIT_DONE: begin
                bus.bram_b_addr = {sec_cnt, bus.sd_buff_addr};
                bus.bram_b_din  = bus.sd_buff_dout;
                bus.bram_b_we   = bus.sd_buff_wr & bus.sd_ack & loading_q;
            end
            default: ;
        endcase
    end

    assign bus.sd_lba = lba_q;
    assign bus.sd_rd  = rd_q;
    assign bus.sd_wr  = wr_q;
    assign busy       = busy_q;
    assign loading    = loading_q;
    assign dirty      = dirty_q;
endmodule
